// File: rtl/alu_scheduler.sv
// Two-requester round-robin front end for the multi-cycle serial ALU.
// One operation in flight; results are returned on a valid/ready channel tagged with the requester id.
module alu_scheduler #(
  parameter int unsigned N   = 8,
  parameter int unsigned LAT = 8,
  parameter int unsigned SW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [2:0]    req0_opcode,
  input  logic [N-1:0]  req0_a,
  input  logic [N-1:0]  req0_b,
  input  logic [SW-1:0] req0_shamt,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [2:0]    req1_opcode,
  input  logic [N-1:0]  req1_a,
  input  logic [N-1:0]  req1_b,
  input  logic [SW-1:0] req1_shamt,
  output logic          alu_inp,
  output logic [2:0]    alu_opcode,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  input  logic [N-1:0]  alu_y,
  input  logic [N-1:0]  alu_y_ext,
  input  logic          alu_ovf,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [N-1:0]  rsp_y,
  output logic [N-1:0]  rsp_y_ext,
  output logic          rsp_ovf,
  output logic          busy
);

  localparam int unsigned KMAX = (LAT > N) ? LAT : N;
  localparam int unsigned CW   = $clog2(KMAX + 1);
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  logic          rr_ptr;
  logic          id_q;
  logic [SW-1:0] shamt_q;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] k_val;

  logic          grant_any;
  logic          grant_id;
  logic [2:0]    sel_opcode;
  logic [N-1:0]  sel_a;
  logic [N-1:0]  sel_b;
  logic [SW-1:0] sel_shamt;
  logic          sel_shift;
  logic          q_shift;

  // Ready is gated by rst so no handshake can complete while reset is held.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state == IDLE && !rst) begin
      case ({req1_valid, req0_valid})
        2'b01:   begin grant_any = 1'b1; grant_id = 1'b0;   end
        2'b10:   begin grant_any = 1'b1; grant_id = 1'b1;   end
        2'b11:   begin grant_any = 1'b1; grant_id = rr_ptr; end
        default: begin grant_any = 1'b0; grant_id = 1'b0;   end
      endcase
    end
  end

  assign req0_ready = grant_any && !grant_id;
  assign req1_ready = grant_any &&  grant_id;

  assign sel_opcode = grant_id ? req1_opcode : req0_opcode;
  assign sel_a      = grant_id ? req1_a      : req0_a;
  assign sel_b      = grant_id ? req1_b      : req0_b;
  assign sel_shamt  = grant_id ? req1_shamt  : req0_shamt;
  assign sel_shift  = (sel_opcode == OP_SHL) || (sel_opcode == OP_SHR);
  assign q_shift    = (alu_opcode == OP_SHL) || (alu_opcode == OP_SHR);

  // Shifts take one cycle per bit position, saturating at the operand width.
  always_comb begin
    k_val = CW'(LAT);
    if (q_shift) begin
      k_val = (32'(shamt_q) > N) ? CW'(N) : CW'(shamt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      id_q       <= 1'b0;
      shamt_q    <= '0;
      wait_cnt   <= '0;
      alu_inp    <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_y      <= '0;
      rsp_y_ext  <= '0;
      rsp_ovf    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            alu_opcode <= sel_opcode;
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            shamt_q    <= sel_shamt;
            id_q       <= grant_id;
            rr_ptr     <= ~grant_id;
            busy       <= 1'b1;
            if (sel_shift && sel_shamt == '0) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_id    <= grant_id;
              rsp_y     <= sel_a;
              rsp_y_ext <= '0;
              rsp_ovf   <= 1'b0;
            end else begin
              state   <= ISSUE;
              alu_inp <= 1'b1;
            end
          end
        end
        ISSUE: begin
          alu_inp  <= 1'b0;
          wait_cnt <= k_val;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - CW'(1);
          if (wait_cnt == CW'(1)) begin
            rsp_y     <= alu_y;
            rsp_y_ext <= alu_y_ext;
            rsp_ovf   <= alu_ovf;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: serial-ALU stub, transaction-level reference model and per-cycle compare.
module tb_alu_scheduler;

  localparam int unsigned N   = 8;
  localparam int unsigned LAT = 8;
  localparam int unsigned SW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          r_valid [2];
  logic [2:0]    r_op    [2];
  logic [N-1:0]  r_a     [2];
  logic [N-1:0]  r_b     [2];
  logic [SW-1:0] r_sh    [2];
  logic          rsp_rdy;

  logic          req0_ready, req1_ready, alu_inp, alu_ovf;
  logic [2:0]    alu_opcode;
  logic [N-1:0]  alu_a, alu_b, alu_y, alu_y_ext;
  logic          rsp_valid, rsp_id, rsp_ovf, busy;
  logic [N-1:0]  rsp_y, rsp_y_ext;

  alu_scheduler #(.N(N), .LAT(LAT), .SW(SW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r_valid[0]), .req0_ready(req0_ready), .req0_opcode(r_op[0]),
    .req0_a(r_a[0]), .req0_b(r_b[0]), .req0_shamt(r_sh[0]),
    .req1_valid(r_valid[1]), .req1_ready(req1_ready), .req1_opcode(r_op[1]),
    .req1_a(r_a[1]), .req1_b(r_b[1]), .req1_shamt(r_sh[1]),
    .alu_inp(alu_inp), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_y_ext(alu_y_ext), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_rdy), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_y_ext(rsp_y_ext), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  // Arithmetic meaning of each opcode; returns {ovf, y_ext, y}.
  function automatic logic [2*N:0] ref_alu(input logic [2:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b, input int sh);
    logic [N:0]     s;
    logic [2*N-1:0] p;
    logic [N-1:0]   y, e;
    logic           o;
    y = '0; e = '0; o = 1'b0; s = '0; p = '0;
    case (op)
      3'b000: begin s = {1'b0, a} + {1'b0, b}; y = s[N-1:0]; o = s[N]; end
      3'b001: begin y = a - b; o = (a < b); end
      3'b010: y = a & b;
      3'b011: y = a | b;
      3'b100: y = a ^ b;
      3'b101: y = (sh >= int'(N)) ? '0 : (a << sh);
      3'b110: y = (sh >= int'(N)) ? '0 : (a >> sh);
      default: begin p = {{N{1'b0}}, a} * {{N{1'b0}}, b}; y = p[N-1:0]; e = p[2*N-1:N]; o = |e; end
    endcase
    return {o, e, y};
  endfunction

  // ALU stub: shifts move one place per cycle after start; other results are
  // correct only in the single cycle the scheduler should sample them.
  int stub_cnt = 1000;
  logic [2*N:0] stub_val;
  always @(posedge clk) begin
    if (alu_inp) stub_cnt <= 0;
    else if (stub_cnt < 1000) stub_cnt <= stub_cnt + 1;
  end
  always_comb begin
    stub_val = ref_alu(alu_opcode, alu_a, alu_b, 0);
    if (alu_opcode == 3'b101 || alu_opcode == 3'b110)
      stub_val = ref_alu(alu_opcode, alu_a, alu_b, stub_cnt + 1);
    else if (stub_cnt != int'(LAT) - 1)
      stub_val = ~stub_val;
    {alu_ovf, alu_y_ext, alu_y} = stub_val;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Transaction model: one op in flight, timed in cycles since its accept edge.
  logic         m_idle = 1'b1;
  int           m_rr = 0;
  int           m_t = 0;
  int           m_k = 0;
  logic         m_zs = 1'b0;
  logic         m_id = 1'b0;
  logic [2:0]   m_op = '0;
  logic [N-1:0] m_a = '0, m_b = '0;
  logic [2*N:0] m_exp = '0;
  logic         last_rdy [2];

  task automatic step();
    logic e_inp, e_rv, sh_op;
    int g;
    #1;
    if (rst) begin m_idle = 1'b1; m_rr = 0; end
    g = -1;
    if (m_idle && !rst) begin
      if (r_valid[0] && r_valid[1]) g = m_rr;
      else if (r_valid[0]) g = 0;
      else if (r_valid[1]) g = 1;
    end
    e_inp = !m_idle && !m_zs && (m_t == 1);
    e_rv  = !m_idle && (m_zs || m_t >= m_k + 2);
    chk("busy", busy, !m_idle);
    chk("alu_inp", alu_inp, e_inp);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("req0_ready", req0_ready, g == 0);
    chk("req1_ready", req1_ready, g == 1);
    if (!m_idle) begin
      chk("alu_opcode", alu_opcode, m_op);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
    end
    if (e_rv) begin
      chk("rsp_y", rsp_y, m_exp[N-1:0]);
      chk("rsp_y_ext", rsp_y_ext, m_exp[2*N-1:N]);
      chk("rsp_ovf", rsp_ovf, m_exp[2*N]);
      chk("rsp_id", rsp_id, m_id);
    end
    last_rdy[0] = req0_ready;
    last_rdy[1] = req1_ready;
    if (!rst) begin
      if (g >= 0) begin
        sh_op  = (r_op[g] == 3'b101) || (r_op[g] == 3'b110);
        m_op   = r_op[g];
        m_a    = r_a[g];
        m_b    = r_b[g];
        m_id   = (g == 1);
        m_zs   = sh_op && (r_sh[g] == '0);
        m_k    = sh_op ? ((int'(r_sh[g]) > int'(N)) ? int'(N) : int'(r_sh[g])) : int'(LAT);
        m_exp  = ref_alu(r_op[g], r_a[g], r_b[g], int'(r_sh[g]));
        m_t    = 1;
        m_rr   = 1 - g;
        m_idle = 1'b0;
      end else if (!m_idle) begin
        if (e_rv && rsp_rdy) m_idle = 1'b1;
        else m_t++;
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req0_ready"}, req0_ready, 0);
    chk({tag, "_req1_ready"}, req1_ready, 0);
    chk({tag, "_alu_inp"}, alu_inp, 0);
    chk({tag, "_alu_opcode"}, alu_opcode, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_y"}, rsp_y, 0);
    chk({tag, "_rsp_y_ext"}, rsp_y_ext, 0);
    chk({tag, "_rsp_ovf"}, rsp_ovf, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic new_req(input int x);
    r_op[x]    = 3'($urandom_range(0, 7));
    r_a[x]     = N'($urandom);
    r_b[x]     = N'($urandom);
    r_sh[x]    = ($urandom_range(0, 2) == 0) ? '0 : SW'($urandom_range(1, 15));
    r_valid[x] = 1'b1;
  endtask

  // Returns with the response visible (rsp_valid high) but not yet handshaken.
  task automatic run_op(input int id, input logic [2:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [SW-1:0] sh,
                        output int lat, output int pulses);
    int n;
    r_op[id] = op; r_a[id] = a; r_b[id] = b; r_sh[id] = sh; r_valid[id] = 1'b1;
    lat = -1; pulses = 0; n = 0;
    do begin step(); n++; end while (!last_rdy[id] && n < 60);
    r_valid[id] = 1'b0;
    chk("accept", last_rdy[id], 1);
    if (!last_rdy[id]) return;
    for (int t = 1; t <= 100; t++) begin
      if (alu_inp) pulses++;
      if (rsp_valid) begin lat = t; break; end
      step();
    end
    if (lat < 0) chk("rsp_valid_timeout", rsp_valid, 1);
  endtask

  task automatic drain();
    rsp_rdy = 1'b1;
    for (int c = 0; c < 300; c++) begin
      for (int x = 0; x < 2; x++) if (last_rdy[x]) r_valid[x] = 1'b0;
      if (!r_valid[0] && !r_valid[1] && m_idle) break;
      step();
    end
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, pulses, n, ng;
    int cnt [2];
    int gseq [8];
    logic [N-1:0] held_y;

    rsp_rdy = 1'b1;
    for (int x = 0; x < 2; x++) begin
      r_valid[x] = 1'b0; r_op[x] = '0; r_a[x] = '0; r_b[x] = '0; r_sh[x] = '0;
      last_rdy[x] = 1'b0;
    end
    #3 chk_zero("reset");
    @(negedge clk);
    step();
    rst = 1'b0;
    step();

    run_op(0, 3'b000, 8'd5, 8'd13, 4'd0, lat, pulses);
    chk("add_latency", lat, 10); chk("add_pulses", pulses, 1);
    chk("add_y", rsp_y, 18); chk("add_ovf", rsp_ovf, 0); chk("add_id", rsp_id, 0);
    step();

    run_op(1, 3'b111, 8'd5, 8'd13, 4'd0, lat, pulses);
    chk("mul_y", rsp_y, 8'h41); chk("mul_y_ext", rsp_y_ext, 8'h00); chk("mul_id", rsp_id, 1);
    step();

    run_op(1, 3'b001, 8'd5, 8'd13, 4'd0, lat, pulses);
    chk("sub_y", rsp_y, 8'hF8);
    step();

    run_op(0, 3'b101, 8'd5, 8'd0, 4'd3, lat, pulses);
    chk("shl_latency", lat, 5); chk("shl_pulses", pulses, 1); chk("shl_y", rsp_y, 40);
    step();

    run_op(0, 3'b110, 8'd5, 8'd0, 4'd0, lat, pulses);
    chk("shr0_latency", lat, 1); chk("shr0_pulses", pulses, 0); chk("shr0_y", rsp_y, 5);
    step();

    run_op(1, 3'b101, 8'h81, 8'd0, 4'd12, lat, pulses);
    chk("shl_clamp_latency", lat, 10); chk("shl_clamp_y", rsp_y, 0);
    step();

    // Contention starting from a known round-robin pointer.
    rst = 1'b1; step(); rst = 1'b0; step();
    cnt[0] = 0; cnt[1] = 0; ng = 0;
    for (int i = 0; i < 8; i++) gseq[i] = -1;
    new_req(0); new_req(1);
    for (int c = 0; c < 400; c++) begin
      if (ng == 8 && m_idle) break;
      step();
      chk("one_ready", {1'b0, last_rdy[0]} + {1'b0, last_rdy[1]} <= 2'd1, 1);
      for (int x = 0; x < 2; x++) begin
        if (last_rdy[x]) begin
          if (ng < 8) gseq[ng] = x;
          ng++; cnt[x]++;
          if (cnt[x] == 4) r_valid[x] = 1'b0; else new_req(x);
        end
      end
    end
    chk("grant_count", ng, 8);
    for (int i = 0; i < 8; i++) chk("grant_order", gseq[i], i % 2);

    // Backpressure: response held while a second request waits.
    rsp_rdy = 1'b0;
    run_op(0, 3'b010, 8'hF0, 8'h3C, 4'd0, lat, pulses);
    chk("and_y", rsp_y, 8'h30);
    held_y = rsp_y;
    r_op[1] = 3'b000; r_a[1] = 8'd1; r_b[1] = 8'd2; r_sh[1] = '0; r_valid[1] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("hold_y", rsp_y, held_y);
      chk("hold_rdy1", last_rdy[1], 0);
      chk("hold_busy", busy, 1);
    end
    rsp_rdy = 1'b1;
    step();
    chk("bp_release_busy", busy, 0);
    chk("bp_release_valid", rsp_valid, 0);
    drain();

    // Reset during WAIT cycle 4.
    r_op[0] = 3'b000; r_a[0] = 8'd5; r_b[0] = 8'd13; r_sh[0] = '0; r_valid[0] = 1'b1;
    n = 0;
    do begin step(); n++; end while (!last_rdy[0] && n < 20);
    r_valid[0] = 1'b0;
    repeat (5) step();
    chk("pre_rst_busy", busy, 1);
    r_valid[1] = 1'b1;
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    step();
    r_valid[1] = 1'b0;
    rst = 1'b0;
    step();
    run_op(0, 3'b000, 8'd200, 8'd100, 4'd0, lat, pulses);
    chk("post_rst_latency", lat, 10); chk("post_rst_y", rsp_y, 44); chk("post_rst_ovf", rsp_ovf, 1);
    step();

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 2500; c++) begin
      for (int x = 0; x < 2; x++) begin
        if (last_rdy[x]) r_valid[x] = 1'b0;
        if (!r_valid[x] && $urandom_range(0, 3) == 0) new_req(x);
      end
      rsp_rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
Name: alu_scheduler

Overview:
Two-requester front end for the multi-cycle serial ALU (`alu`, N-bit, start pulse on `inp`).
- Arbitrates round-robin between two request ports and latches the winner's opcode and operands.
- Issues a one-cycle start pulse, holds the operands stable, and waits the op-dependent latency.
- Captures y/y_ext/ovf and returns them on a valid/ready response channel tagged with the requester id.
- Only one operation is in flight at a time.

Parameters:
- N, 8, operand/result width; must match the attached alu.
- LAT, 8, clock cycles after the start pulse until alu y/y_ext/ovf are final for opcodes 000-100 and 111.
- SW, 4, shift-amount width (= $clog2(N+1)).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_opcode  in  3  ALU opcode.
- req0_a, req0_b  in  N  operands.
- req0_shamt  in  SW  shift count; used only for opcodes 101/110.
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b, req1_shamt: same as requester 0, for requester 1.
- alu_inp  out  1  start pulse to alu.
- alu_opcode  out  3  to alu.
- alu_a, alu_b  out  N  to alu.
- alu_y, alu_y_ext  in  N  from alu.
- alu_ovf  in  1  from alu.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that issued the result.
- rsp_y, rsp_y_ext  out  N  captured result.
- rsp_ovf  out  1  captured overflow.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous:
  - state=IDLE, rr_ptr=0.
  - All outputs 0: alu_inp, alu_opcode/a/b, req*_ready, rsp_valid, rsp_id, rsp_y, rsp_y_ext, rsp_ovf, busy.
  - wait counter=0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, arbitration:
  - If exactly one reqX_valid is high, grant X.
  - If both are high, grant rr_ptr; rr_ptr then becomes the other requester.
  - After a single-request grant, rr_ptr also becomes the non-granted requester.
  - reqX_ready is combinational, high only in IDLE for the granted X; at most one ready per cycle.
  - On the accept edge, latch opcode/a/b/shamt/id into registers driving alu_opcode/a/b.
- Next state after accept:
  - Shift opcodes (101/110) with shamt=0: go directly to DONE with rsp_y=a, rsp_y_ext=0, rsp_ovf=0; no ALU start pulse.
  - Otherwise: go to ISSUE.
- ISSUE, one cycle:
  - alu_inp=1 (registered); otherwise alu_inp=0 in all states.
  - Load wait counter with k: k=shamt (clamped to N) for 101/110, k=LAT for all others. Go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On the edge ending the k-th WAIT cycle, capture alu_y, alu_y_ext, alu_ovf into rsp_* and go to DONE.
  - alu_opcode/a/b are held constant from the accept edge through this capture.
- DONE:
  - rsp_valid=1 and rsp_* are stable.
  - When rsp_valid and rsp_ready are both high, return to IDLE; rsp_valid=0 on the next cycle.
  - rsp_ready low holds DONE indefinitely, with no new accepts.
- Latency: accept edge to rsp_valid high = k+2 cycles. Shift with shamt=0: 1 cycle.
- Back-to-back: the earliest next accept is the cycle after the response handshake; there is no bubble beyond IDLE.
- Requests not granted are left pending; the requester must hold valid and data stable until ready.
- Reset asserted mid-ISSUE/WAIT/DONE: abort immediately to the reset values; the in-flight op is dropped and no response is issued.
- rsp_y_ext is meaningful for 111 only; captured as-is for all opcodes.

Test Plan:
- Add, req0: opcode 000, a=5, b=13, LAT=8, rsp_ready=1 → alu_inp high exactly 1 cycle; rsp_valid 10 cycles after accept; rsp_y=18, rsp_ovf=0, rsp_id=0.
- Multiply, req1: opcode 111, a=5, b=13 → rsp_y=0x41, rsp_y_ext=0x00, rsp_id=1. Then opcode 001, a=5, b=13 → rsp_y=0xF8.
- Contention: req0 and req1 both valid continuously, 4 ops each → grants alternate 0,1,0,1,…; never two readies in one cycle; rsp_id sequence matches.
- Shift: opcode 101, a=5, shamt=3 → capture 3 cycles after ISSUE, rsp_y=40. Opcode 110, a=5, shamt=0 → no alu_inp pulse, rsp_y=5, one cycle after accept.
- Backpressure: hold rsp_ready=0 for 20 cycles in DONE → rsp_* stable, req*_ready=0, busy=1; raise rsp_ready → IDLE next cycle.
- Reset at WAIT cycle 4 → all outputs 0 asynchronously; after release, a new add (a=200, b=100) completes with rsp_y=44, rsp_ovf=1.
